// File: rtl/exmem_pipe_if.sv
// exmem_pipe_if: EX->MEM pipeline bus. Carries the upstream handshake and
// payload, the downstream handshake and payload, and the flush request.
// The master modport is the side that drives the pipe (the surrounding core);
// the slave modport is the pipe itself.
interface exmem_pipe_if #(
  parameter int DATA_W   = 64,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5
);
  logic                       flush_i;
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic                       reg_write_en_i;
  logic                       mem_write_en_i;
  logic [NUM_DATA*DATA_W-1:0] data_i;
  logic [RD_W-1:0]            rd_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic                       reg_write_en_o;
  logic                       mem_write_en_o;
  logic [NUM_DATA*DATA_W-1:0] data_o;
  logic [RD_W-1:0]            rd_o;

  modport master (
    output flush_i, in_valid_i, reg_write_en_i, mem_write_en_i, data_i, rd_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, reg_write_en_o, mem_write_en_o, data_o, rd_o
  );

  modport slave (
    input  flush_i, in_valid_i, reg_write_en_i, mem_write_en_i, data_i, rd_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, reg_write_en_o, mem_write_en_o, data_o, rd_o
  );
endinterface

// File: rtl/exmem_pipe.sv
// exmem_pipe: elastic EX->MEM pipeline register, STAGES stages in series.
// Build option EXMEM_PIPE_SKID_EN:
//   defined   - each stage has a main and a skid entry (EMPTY/FULL/SKID) and a
//               registered ready (ready = not SKID); capacity 2*STAGES.
//   undefined - each stage has a single main entry (EMPTY/FULL); ready is
//               combinational (downstream ready OR not FULL); capacity STAGES.
// Payload per entry is {reg_write_en, mem_write_en, rd, data}. Flush empties
// every stage on the next edge; reset does the same and also zeroes payload.
module exmem_pipe #(
  parameter int DATA_W   = 64,
  parameter int NUM_DATA = 2,
  parameter int RD_W     = 5,
  parameter int STAGES   = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  exmem_pipe_if.slave  bus
);
  localparam int DW = NUM_DATA * DATA_W;
  localparam int PW = DW + RD_W + 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  logic [PW-1:0] w_in_pay;
  logic [PW-1:0] w_last;

  assign w_in_pay = {bus.reg_write_en_i, bus.mem_write_en_i, bus.rd_i, bus.data_i};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          w_iv;
    logic [PW-1:0] w_ip;
    logic          w_ordy;
    logic          w_vld_s;
    logic          w_rdy_s;
    logic          w_acc;
    logic          w_drn;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_main;

    if (k == 0) begin : g_src_in
      assign w_iv = bus.in_valid_i;
      assign w_ip = w_in_pay;
    end else begin : g_src_prev
      assign w_iv = g_stage[k-1].w_vld_s;
      assign w_ip = g_stage[k-1].r_main;
    end

    if (k == STAGES - 1) begin : g_snk_out
      assign w_ordy = bus.out_ready_i;
    end else begin : g_snk_next
      assign w_ordy = g_stage[k+1].w_rdy_s;
    end

    assign w_acc = w_iv & w_rdy_s;
    assign w_drn = w_vld_s & w_ordy;

    // State register: reset and flush both land in EMPTY (flush via next-state)
    always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= ST_EMPTY;
      else       r_state <= w_state_nxt;
    end

`ifdef EXMEM_PIPE_SKID_EN
    logic [PW-1:0] r_skid;

    // Next-state: accept/drain bookkeeping for main + skid entries
    always_comb begin
      w_state_nxt = r_state;
      if (bus.flush_i) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: if (w_acc) w_state_nxt = ST_FULL;
          ST_FULL: begin
            if (w_acc && !w_drn)      w_state_nxt = ST_SKID;
            else if (!w_acc && w_drn) w_state_nxt = ST_EMPTY;
          end
          ST_SKID:  if (w_drn) w_state_nxt = ST_FULL;
          default:  w_state_nxt = ST_EMPTY;
        endcase
      end
    end

    // Outputs: ready comes straight from the state flop, so it is registered
    always_comb begin
      w_vld_s = (r_state != ST_EMPTY);
      w_rdy_s = (r_state != ST_SKID);
    end

    // Payload: load main on accept, park in skid when stalled, promote skid on drain
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_main <= '0;
        r_skid <= '0;
      end else if (!bus.flush_i) begin
        case (r_state)
          ST_EMPTY: if (w_acc) r_main <= w_ip;
          ST_FULL: begin
            if (w_acc && w_drn) r_main <= w_ip;
            else if (w_acc)     r_skid <= w_ip;
          end
          ST_SKID:  if (w_drn) r_main <= r_skid;
          default: ;
        endcase
      end
    end
`else
    // Next-state: single entry, refill in the same cycle it drains
    always_comb begin
      w_state_nxt = r_state;
      if (bus.flush_i) begin
        w_state_nxt = ST_EMPTY;
      end else begin
        case (r_state)
          ST_EMPTY: if (w_acc) w_state_nxt = ST_FULL;
          ST_FULL:  if (w_drn && !w_acc) w_state_nxt = ST_EMPTY;
          default:  w_state_nxt = ST_EMPTY;
        endcase
      end
    end

    // Outputs: ready ripples combinationally from downstream when full
    always_comb begin
      w_vld_s = (r_state == ST_FULL);
      w_rdy_s = (r_state != ST_FULL) | w_ordy;
    end

    // Payload: load on accept; flushed cycles never load
    always_ff @(posedge clk_i) begin
      if (rst_i)                     r_main <= '0;
      else if (!bus.flush_i && w_acc) r_main <= w_ip;
    end
`endif
  end

  assign w_last             = g_stage[STAGES-1].r_main;
  assign bus.in_ready_o     = g_stage[0].w_rdy_s;
  assign bus.out_valid_o    = g_stage[STAGES-1].w_vld_s;
  assign bus.reg_write_en_o = w_last[PW-1] & bus.out_valid_o;
  assign bus.mem_write_en_o = w_last[PW-2] & bus.out_valid_o;
  assign bus.rd_o           = w_last[DW +: RD_W];
  assign bus.data_o         = w_last[DW-1:0];

endmodule

// File: tb/tb_exmem_pipe.sv
// tb_exmem_pipe: directed bench for exmem_pipe. Two instances share one clock
// and reset: u_dut2 (STAGES=2) and u_dut1 (STAGES=1). Expectations that depend
// on EXMEM_PIPE_SKID_EN are selected with the same macro.
module tb_exmem_pipe;
  localparam int DATA_W   = 16;
  localparam int NUM_DATA = 2;
  localparam int RD_W     = 5;
  localparam int DW       = DATA_W * NUM_DATA;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp;
  int   n_bad;

  always #5 clk = ~clk;

  exmem_pipe_if #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W)) if2 ();
  exmem_pipe_if #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W)) if1 ();

  exmem_pipe #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .STAGES(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(if2)
  );
  exmem_pipe #(.DATA_W(DATA_W), .NUM_DATA(NUM_DATA), .RD_W(RD_W), .STAGES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1)
  );

  // Payload for an entry with index r: channel1 = D0rr, channel0 = C0rr
  function automatic logic [DW-1:0] pay(input int r);
    logic [15:0] v;
    v = 16'(r);
    return {16'hD000 | v, 16'hC000 | v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv2(input logic v, input int r, input logic rwe, input logic mwe);
    if2.in_valid_i     = v;
    if2.rd_i           = RD_W'(r);
    if2.data_i         = pay(r);
    if2.reg_write_en_i = rwe;
    if2.mem_write_en_i = mwe;
  endtask

  task automatic drv1(input logic v, input int r, input logic rwe, input logic mwe);
    if1.in_valid_i     = v;
    if1.rd_i           = RD_W'(r);
    if1.data_i         = pay(r);
    if1.reg_write_en_i = rwe;
    if1.mem_write_en_i = mwe;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv2(1'b1, 7, 1'b1, 1'b1); drv1(1'b1, 7, 1'b1, 1'b1);
    if2.flush_i = 1'b0; if1.flush_i = 1'b0;
    if2.out_ready_i = 1'b1; if1.out_ready_i = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    n_cmp++; if (if2.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid2: got %b want 0", if2.out_valid_o); end
    n_cmp++; if (if2.data_o !== '0) begin n_bad++; $display("FAIL reset_data2: got %h want 0", if2.data_o); end
    n_cmp++; if (if2.rd_o !== '0) begin n_bad++; $display("FAIL reset_rd2: got %0d want 0", if2.rd_o); end
    n_cmp++; if (if2.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready2: got %b want 1", if2.in_ready_o); end
    n_cmp++; if (if2.reg_write_en_o !== 1'b0) begin n_bad++; $display("FAIL reset_rwe2: got %b want 0", if2.reg_write_en_o); end
    n_cmp++; if (if1.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid1: got %b want 0", if1.out_valid_o); end
    n_cmp++; if (if1.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready1: got %b want 1", if1.in_ready_o); end
    step();
    rst = 1'b0;
    drv2(1'b0, 0, 1'b0, 1'b0); drv1(1'b0, 0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (if2.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_after_valid2 c=%0d: got %b want 0", c, if2.out_valid_o); end
      n_cmp++; if (if1.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_after_valid1 c=%0d: got %b want 0", c, if1.out_valid_o); end
      step();
    end
  endtask

  task automatic test_stream();
    logic [4:0] r;
    logic       ev;
    if2.out_ready_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      r = 5'(c + 1);
      if (c < 8) drv2(1'b1, c + 1, r[0], r[1]);
      else       drv2(1'b0, 0, 1'b0, 1'b0);
      @(negedge clk);
      ev = (c >= 2 && c <= 9);
      n_cmp++; if (if2.out_valid_o !== ev) begin n_bad++; $display("FAIL stream_valid c=%0d: got %b want %b", c, if2.out_valid_o, ev); end
      n_cmp++; if (if2.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL stream_ready c=%0d: got %b want 1", c, if2.in_ready_o); end
      if (ev) begin
        r = 5'(c - 1);
        n_cmp++; if (if2.rd_o !== r) begin n_bad++; $display("FAIL stream_rd c=%0d: got %0d want %0d", c, if2.rd_o, r); end
        n_cmp++; if (if2.reg_write_en_o !== r[0]) begin n_bad++; $display("FAIL stream_rwe c=%0d: got %b want %b", c, if2.reg_write_en_o, r[0]); end
        n_cmp++; if (if2.mem_write_en_o !== r[1]) begin n_bad++; $display("FAIL stream_mwe c=%0d: got %b want %b", c, if2.mem_write_en_o, r[1]); end
        n_cmp++; if (if2.data_o !== pay(c - 1)) begin n_bad++; $display("FAIL stream_data c=%0d: got %h want %h", c, if2.data_o, pay(c - 1)); end
      end
      step();
    end
  endtask

  // Columns: in_valid, rd_in, out_ready, exp in_ready, exp out_valid, exp rd_o (-1 = don't care)
`ifdef EXMEM_PIPE_SKID_EN
  localparam int BP_N = 8;
  int bp_tab [BP_N][6] = '{
    '{1, 3, 0, 1, 0, -1},
    '{1, 4, 0, 1, 1,  3},
    '{1, 5, 0, 0, 1,  3},
    '{1, 5, 0, 0, 1,  3},
    '{1, 5, 1, 0, 1,  3},
    '{1, 5, 1, 1, 1,  4},
    '{0, 0, 1, 1, 1,  5},
    '{0, 0, 1, 1, 0,  5}
  };
`else
  localparam int BP_N = 5;
  int bp_tab [BP_N][6] = '{
    '{1, 3, 0, 1, 0, -1},
    '{1, 4, 0, 0, 1,  3},
    '{1, 5, 1, 1, 1,  4},
    '{0, 0, 1, 1, 1,  5},
    '{0, 0, 1, 1, 0,  5}
  };
`endif

  task automatic test_backpressure();
    logic [4:0] er;
    for (int c = 0; c < BP_N; c++) begin
      drv1(bp_tab[c][0] != 0, bp_tab[c][1], 1'b1, 1'b0);
      if1.out_ready_i = (bp_tab[c][2] != 0);
      @(negedge clk);
      n_cmp++; if (if1.in_ready_o !== (bp_tab[c][3] != 0)) begin n_bad++; $display("FAIL bp_ready c=%0d: got %b want %0d", c, if1.in_ready_o, bp_tab[c][3]); end
      n_cmp++; if (if1.out_valid_o !== (bp_tab[c][4] != 0)) begin n_bad++; $display("FAIL bp_valid c=%0d: got %b want %0d", c, if1.out_valid_o, bp_tab[c][4]); end
      n_cmp++; if (if1.reg_write_en_o !== (bp_tab[c][4] != 0)) begin n_bad++; $display("FAIL bp_rwe c=%0d: got %b want %0d", c, if1.reg_write_en_o, bp_tab[c][4]); end
      if (bp_tab[c][5] >= 0) begin
        er = 5'(bp_tab[c][5]);
        n_cmp++; if (if1.rd_o !== er) begin n_bad++; $display("FAIL bp_rd c=%0d: got %0d want %0d", c, if1.rd_o, er); end
      end
`ifndef EXMEM_PIPE_SKID_EN
      if (c == 1) begin
        if1.out_ready_i = 1'b1;
        #1;
        n_cmp++; if (if1.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_comb_ready: got %b want 1", if1.in_ready_o); end
      end
`endif
      step();
    end
    drv1(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    if2.out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drv2(1'b1, c + 1, 1'b0, 1'b1);
      step();
    end
    drv2(1'b1, 9, 1'b1, 1'b1);
    if2.flush_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (if2.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL flush_pre_valid: got %b want 1", if2.out_valid_o); end
    n_cmp++; if (if2.rd_o !== 5'd1) begin n_bad++; $display("FAIL flush_pre_rd: got %0d want 1", if2.rd_o); end
    step();
    if2.flush_i = 1'b0;
    drv2(1'b0, 0, 1'b0, 1'b0);
    if2.out_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (if2.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", if2.out_valid_o); end
    n_cmp++; if (if2.mem_write_en_o !== 1'b0) begin n_bad++; $display("FAIL flush_mwe: got %b want 0", if2.mem_write_en_o); end
    n_cmp++; if (if2.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", if2.in_ready_o); end
    step();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (if2.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_after_valid c=%0d: got %b rd %0d want 0", c, if2.out_valid_o, if2.rd_o); end
      step();
    end
  endtask

  task automatic test_flush_hold();
    if1.out_ready_i = 1'b1;
    if1.flush_i = 1'b1;
    drv1(1'b1, 20, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (if1.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL flushhold_ready c=%0d: got %b want 1", c, if1.in_ready_o); end
      n_cmp++; if (if1.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flushhold_valid c=%0d: got %b want 0", c, if1.out_valid_o); end
      step();
    end
    if1.flush_i = 1'b0;
    drv1(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++; if (if1.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL flushhold_after_valid: got %b want 0", if1.out_valid_o); end
    step();
  endtask

  task automatic test_reset_mid();
    if2.out_ready_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drv2(1'b1, 10 + c, 1'b1, 1'b1);
      step();
    end
    @(negedge clk);
    n_cmp++; if (if2.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_full_ready: got %b want 0", if2.in_ready_o); end
    n_cmp++; if (if2.out_valid_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_full_valid: got %b want 1", if2.out_valid_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv2(1'b0, 0, 1'b0, 1'b0);
    if2.out_ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (if2.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready: got %b want 1", if2.in_ready_o); end
    n_cmp++; if (if2.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", if2.out_valid_o); end
    n_cmp++; if (if2.rd_o !== '0) begin n_bad++; $display("FAIL rstmid_rd: got %0d want 0", if2.rd_o); end
    n_cmp++; if (if2.data_o !== '0) begin n_bad++; $display("FAIL rstmid_data: got %h want 0", if2.data_o); end
    n_cmp++; if (if2.reg_write_en_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_rwe: got %b want 0", if2.reg_write_en_o); end
    step();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (if2.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_after_valid c=%0d: got %b want 0", c, if2.out_valid_o); end
      step();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_flush_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
